cim_bitserial_accum: RTL and testbench
======================================

Name: cim_bitserial_accum

Overview:
- Multi-channel, parametrised bit-serial shift-and-accumulate for the CIM macro output path.
- Each transaction receives one signed partial sum per channel per input bit-plane, LSB plane first.
- Each beat is weighted by 2^plane_index; in signed mode the MSB plane is subtracted.
- Sits between the CIM column ADC/readout and the SoC result buffer, with valid/ready handshakes on both sides and runtime-selectable precision.

Parameters:
- NCH, 4: number of independent channels (columns) accumulated in parallel.
- DW, 10: signed width of each per-channel input sample.
- MAXBITS, 8: maximum input precision (bit-planes per transaction), >=2.
- AW, DW+MAXBITS: per-channel accumulator/output width (derived; do not override).
- NBW, $clog2(MAXBITS+1): width of the nbits config port.

Ports:
- clk  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: latch config, clear accumulators, begin transaction.
- nbits  in  NBW  planes in this transaction; sampled on start.
- sgn_mode  in  1  1 = two's-complement input (MSB plane subtracted), 0 = unsigned input; sampled on start.
- abort  in  1  drop the current transaction and return to IDLE.
- in_valid  in  1  in_data beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  NCH*DW  channel c at bits [c*DW +: DW], signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  NCH*AW  channel c at bits [c*AW +: AW], signed.
- busy  out  1  high in ACC or DONE.
- cfg_err  out  1  one-cycle pulse: illegal nbits at start.

Behaviour:
- Reset (RSTN low, async): state=IDLE; all accumulators, plane index, out_data = 0; in_ready, out_valid, busy, cfg_err = 0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch nbits and sgn_mode, clear all accumulators, idx=0, go to ACC next cycle.
  - nbits=0 or nbits>MAXBITS: clamp to MAXBITS and pulse cfg_err in the cycle after start.
- ACC:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready; gaps (in_valid low) hold state with no timeout.
  - On each accepted beat: acc[c] <= acc[c] + (sext(in_data[c]) << idx), computed at AW bits.
  - Exception: when sgn_mode=1 and idx==nbits-1, the term is subtracted instead of added.
  - After acceptance, idx increments. Acceptance of the beat with idx==nbits-1 moves to DONE.
- DONE:
  - out_valid=1 and out_data=acc; in_ready=0.
  - out_valid is asserted the cycle after the last beat is accepted (latency 1).
  - out_data is stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE next cycle; out_data retains its value, out_valid drops.
- Start outside IDLE: ignored, with no effect on the transaction.
- Start in the same cycle as the DONE handshake: ignored; the new transaction requires a start in IDLE.
- Abort (any state): next cycle state=IDLE, out_valid=0, accumulators cleared.
  - Abort has priority over start and over beat acceptance in the same cycle.
- nbits=1: a single beat. Signed mode gives -data, unsigned gives +data.
- Arithmetic is exact; no overflow is possible. |in| <= 2^(DW-1), so the sum is bounded by 2^(DW-1)*(2^MAXBITS-1) < 2^(AW-1).
- Channels are fully independent; no cross-channel carry.
- Reset asserted mid-ACC or mid-DONE: immediate return to the reset values; no partial result is ever presented.

Test Plan:
- Signed, nbits=8, ch0 data=+1 on all 8 planes, other channels 0 -> out_valid one cycle after the 8th beat; ch0=-1 (127-128), ch1..3=0.
- Unsigned, nbits=8, ch0=+1 and ch1=-512 on all planes -> ch0=255, ch1=-130560; no wrap in the 18-bit output.
- Signed, nbits=3, ch2 planes {5,-3,7} with in_valid gaps of 2 cycles between beats -> ch2=5-6-28=-29; in_ready high throughout ACC.
- Backpressure: hold out_ready low 5 cycles in DONE, pulse start during this time -> out_data stable, start ignored, IDLE reached after the out_ready handshake.
- start with nbits=0 -> cfg_err pulses once; exactly 8 beats are consumed before out_valid.
- Abort after 3 beats, and separately RSTN low after 3 beats -> IDLE, out_valid=0; the next transaction (nbits=2 unsigned, {1,1}) yields 3, with no residue from the aborted run.

Source files
------------

// File: rtl/cim_bitserial_accum_if.sv
// ---------------------------------------------------------------------------
// cim_bitserial_accum_if
//
// Purpose:
//   Bundles the control, input-beat and result handshakes of the CIM
//   bit-serial shift-and-accumulate block. Clock and reset stay outside.
//
// Signals:
//   start     - one-cycle pulse that begins a transaction
//   nbits     - number of bit-planes in the transaction (sampled on start)
//   sgn_mode  - 1 = two's-complement input, 0 = unsigned (sampled on start)
//   abort     - drop the current transaction
//   in_valid  - in_data beat is valid
//   in_ready  - block accepts a beat
//   in_data   - NCH signed samples, channel c at [c*DW +: DW]
//   out_valid - result is valid
//   out_ready - consumer accepts the result
//   out_data  - NCH signed sums, channel c at [c*AW +: AW]
//   busy      - a transaction is accumulating or waiting for hand-off
//   cfg_err   - one-cycle pulse: illegal nbits was clamped
//
// Modports:
//   master - the side that drives transactions (readout / testbench)
//   slave  - the accumulator itself
// ---------------------------------------------------------------------------
interface cim_bitserial_accum_if #(
    parameter int NCH     = 4,
    parameter int DW      = 10,
    parameter int MAXBITS = 8
);
    localparam int AW  = DW + MAXBITS;
    localparam int NBW = $clog2(MAXBITS + 1);

    logic               start;
    logic [NBW-1:0]     nbits;
    logic               sgn_mode;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [NCH*DW-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NCH*AW-1:0]  out_data;
    logic               busy;
    logic               cfg_err;

    modport master (
        output start, nbits, sgn_mode, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, cfg_err
    );

    modport slave (
        input  start, nbits, sgn_mode, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, cfg_err
    );
endinterface

// File: rtl/cim_bitserial_accum.sv
// ---------------------------------------------------------------------------
// cim_bitserial_accum
//
// Purpose:
//   Multi-channel bit-serial shift-and-accumulate for the CIM macro output
//   path. A transaction delivers one signed partial sum per channel for each
//   input bit-plane, LSB plane first. Plane i is weighted by 2^i; in signed
//   mode the MSB plane carries weight -2^(n-1). The finished per-channel sums
//   are handed to the result buffer through a valid/ready handshake.
//
// Ports:
//   clk  - rising-edge clock
//   RSTN - asynchronous active-low reset
//   bus  - cim_bitserial_accum_if.slave (control, input beats, results,
//          busy and cfg_err status)
// ---------------------------------------------------------------------------
module cim_bitserial_accum #(
    parameter int NCH     = 4,
    parameter int DW      = 10,
    parameter int MAXBITS = 8
) (
    input  logic                   clk,
    input  logic                   RSTN,
    cim_bitserial_accum_if.slave   bus
);
    localparam int AW  = DW + MAXBITS;
    localparam int NBW = $clog2(MAXBITS + 1);
    localparam logic [NBW-1:0] MAXN = NBW'(MAXBITS);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [NBW-1:0]           nbits_q, nbits_d;
    logic [NBW-1:0]           idx_q, idx_d;
    logic                     sgnMode_q, sgnMode_d;
    logic                     cfgErr_q, cfgErr_d;
    logic [NCH-1:0][AW-1:0]   acc_q, acc_d;

    logic                     nbitsLegal;
    logic                     lastBeat;
    logic                     beatFire;
    logic [AW-1:0]            term [NCH];

    // Zero planes or more planes than the datapath supports are both treated
    // as a full-precision transaction; the caller is told via cfg_err.
    assign nbitsLegal = (bus.nbits != '0) && (bus.nbits <= MAXN);
    // nbits_q is never zero while accumulating, so the subtraction cannot wrap.
    assign lastBeat   = (idx_q == (nbits_q - NBW'(1)));
    assign beatFire   = bus.in_valid && (state_q == ACC);

    // Each channel's sample is sign-extended to the full accumulator width
    // before shifting so negative partial sums keep their weight exactly.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            term[c] = {{(AW-DW){bus.in_data[c*DW + DW - 1]}}, bus.in_data[c*DW +: DW]} << idx_q;
        end
    end

    // State and datapath registers. Reset clears everything so that no
    // partial result can ever be seen after a mid-transaction reset.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            nbits_q   <= '0;
            idx_q     <= '0;
            sgnMode_q <= 1'b0;
            cfgErr_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            nbits_q   <= nbits_d;
            idx_q     <= idx_d;
            sgnMode_q <= sgnMode_d;
            cfgErr_q  <= cfgErr_d;
            acc_q     <= acc_d;
        end
    end

    // Next-state logic. Abort wins over everything else in the same cycle,
    // and start is only honoured in IDLE (including the cycle of the DONE
    // hand-off, where the state is still DONE).
    always_comb begin
        state_d   = state_q;
        nbits_d   = nbits_q;
        idx_d     = idx_q;
        sgnMode_d = sgnMode_q;
        cfgErr_d  = 1'b0;
        acc_d     = acc_q;

        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        nbits_d   = nbitsLegal ? bus.nbits : MAXN;
                        sgnMode_d = bus.sgn_mode;
                        cfgErr_d  = !nbitsLegal;
                        idx_d     = '0;
                        acc_d     = '0;
                        state_d   = ACC;
                    end
                end
                ACC: begin
                    if (beatFire) begin
                        // The MSB plane of a two's-complement input has negative weight.
                        for (int c = 0; c < NCH; c++) begin
                            if (sgnMode_q && lastBeat) begin
                                acc_d[c] = acc_q[c] - term[c];
                            end else begin
                                acc_d[c] = acc_q[c] + term[c];
                            end
                        end
                        idx_d = idx_q + NBW'(1);
                        if (lastBeat) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state, so out_data is the
    // accumulator itself and stays put while the consumer stalls and after
    // the hand-off until the next start or abort.
    always_comb begin
        bus.in_ready  = (state_q == ACC);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.cfg_err   = cfgErr_q;
        bus.out_data  = acc_q;
    end
endmodule

// File: tb/tb_cim_bitserial_accum.sv
// ---------------------------------------------------------------------------
// tb_cim_bitserial_accum
//
// Purpose:
//   Self-checking bench for cim_bitserial_accum. Directed transactions are
//   described as per-plane, per-channel integer tables; the expected sums
//   come from a weighted-sum model, and a compare process checks out_data
//   against that model on every cycle that out_valid is high.
// ---------------------------------------------------------------------------
module tb_cim_bitserial_accum;
    localparam int NCH     = 4;
    localparam int DW      = 10;
    localparam int MAXBITS = 8;
    localparam int AW      = DW + MAXBITS;
    localparam int NBW     = $clog2(MAXBITS + 1);

    logic clk = 1'b0;
    logic RSTN;

    int testCount = 0;
    int failCount = 0;

    int                 stim [MAXBITS][NCH];
    longint             modelExp [NCH];
    bit                 modelArmed = 1'b0;
    logic [NCH*AW-1:0]  lastOut;

    cim_bitserial_accum_if #(.NCH(NCH), .DW(DW), .MAXBITS(MAXBITS)) bus ();

    cim_bitserial_accum #(.NCH(NCH), .DW(DW), .MAXBITS(MAXBITS)) dut (
        .clk  (clk),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Generic scalar comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Signed value of one channel of a packed result vector.
    function automatic longint chanOf(input logic [NCH*AW-1:0] v, input int c);
        logic signed [AW-1:0] s;
        s = v[c*AW +: AW];
        return longint'(s);
    endfunction

    task automatic clearStim();
        for (int i = 0; i < MAXBITS; i++)
            for (int c = 0; c < NCH; c++)
                stim[i][c] = 0;
    endtask

    // Whenever a result is presented it must match the weighted-sum model of
    // the transaction in flight; a result with nothing in flight is an error.
    always @(negedge clk) begin
        if (RSTN === 1'b1 && bus.out_valid === 1'b1) begin
            if (!modelArmed) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                for (int c = 0; c < NCH; c++)
                    checkOutput($sformatf("model_ch%0d", c), chanOf(bus.out_data, c), modelExp[c]);
            end
        end
    end

    // Starts a transaction and feeds beatsToSend planes from stim, with gap
    // idle cycles between beats. The model result is the sum of
    // plane_value * 2^plane, with the top plane negated in signed mode.
    task automatic applyStimulus(input int n, input bit sgn, input int gap, input int beatsToSend);
        int effN;
        longint w;
        int waitCycles;
        effN = (n == 0 || n > MAXBITS) ? MAXBITS : n;
        for (int c = 0; c < NCH; c++) begin
            modelExp[c] = 0;
            for (int i = 0; i < effN; i++) begin
                w = longint'(1) << i;
                if (sgn && i == effN - 1) w = -w;
                modelExp[c] += longint'(stim[i][c]) * w;
            end
        end
        modelArmed = (beatsToSend == effN);

        bus.start    = 1'b1;
        bus.nbits    = NBW'(n);
        bus.sgn_mode = sgn;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("cfg_err_pulse", bus.cfg_err, (n == 0 || n > MAXBITS) ? 1 : 0);
        checkOutput("busy_in_acc", bus.busy, 1);

        for (int i = 0; i < beatsToSend; i++) begin
            bus.in_valid = 1'b1;
            for (int c = 0; c < NCH; c++)
                bus.in_data[c*DW +: DW] = DW'(stim[i][c]);
            waitCycles = 0;
            while (bus.in_ready !== 1'b1 && waitCycles < 20) begin
                @(negedge clk);
                waitCycles++;
            end
            if (bus.in_ready !== 1'b1) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL in_ready_timeout: got %b, expected 1", bus.in_ready);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("out_valid_after_beat%0d", i), bus.out_valid, (i == effN - 1) ? 1 : 0);
            if (i == 0) checkOutput("cfg_err_one_cycle", bus.cfg_err, 0);
            if (i == effN - 1) begin
                lastOut = bus.out_data;
            end else begin
                for (int g = 0; g < gap; g++) begin
                    checkOutput("in_ready_in_gap", bus.in_ready, 1);
                    @(negedge clk);
                end
            end
        end
    endtask

    // Holds the result for hold cycles, optionally pulsing start while the
    // result waits and again together with the hand-off; neither start may
    // launch a new transaction.
    task automatic finishTxn(input int hold, input bit pulseStart);
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            bus.start = pulseStart && (k == 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            checkOutput("hold_out_valid", bus.out_valid, 1);
            checkOutput("hold_out_data_stable", (bus.out_data === lastOut) ? 1 : 0, 1);
        end
        bus.out_ready = 1'b1;
        bus.start     = pulseStart;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        @(negedge clk);
        modelArmed = 1'b0;
        checkOutput("post_hs_out_valid", bus.out_valid, 0);
        checkOutput("post_hs_busy", bus.busy, 0);
        checkOutput("post_hs_data_retained", (bus.out_data === lastOut) ? 1 : 0, 1);
        @(negedge clk);
        checkOutput("start_ignored_stay_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RSTN          = 1'b0;
        bus.start     = 1'b0;
        bus.nbits     = '0;
        bus.sgn_mode  = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clearStim();

        // Reset values.
        #12;
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_cfg_err", bus.cfg_err, 0);
        checkOutput("reset_out_data", (bus.out_data === '0) ? 1 : 0, 1);
        @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);

        // Signed, 8 planes of +1 on ch0: 127 - 128 = -1.
        clearStim();
        for (int i = 0; i < 8; i++) stim[i][0] = 1;
        applyStimulus(8, 1'b1, 0, 8);
        checkOutput("t1_model_pin", modelExp[0], -1);
        checkOutput("t1_ch0", chanOf(lastOut, 0), -1);
        checkOutput("t1_ch1", chanOf(lastOut, 1), 0);
        checkOutput("t1_ch3", chanOf(lastOut, 3), 0);
        finishTxn(0, 1'b0);

        // Unsigned, 8 planes: ch0 = +1 -> 255, ch1 = -512 -> -130560.
        clearStim();
        for (int i = 0; i < 8; i++) begin
            stim[i][0] = 1;
            stim[i][1] = -512;
        end
        applyStimulus(8, 1'b0, 0, 8);
        checkOutput("t2_ch0", chanOf(lastOut, 0), 255);
        checkOutput("t2_ch1", chanOf(lastOut, 1), -130560);
        finishTxn(1, 1'b0);

        // Signed, 3 planes on ch2 {5,-3,7} with 2-cycle gaps: 5 - 6 - 28 = -29.
        clearStim();
        stim[0][2] = 5;
        stim[1][2] = -3;
        stim[2][2] = 7;
        applyStimulus(3, 1'b1, 2, 3);
        checkOutput("t3_model_pin", modelExp[2], -29);
        checkOutput("t3_ch2", chanOf(lastOut, 2), -29);
        finishTxn(0, 1'b0);

        // Backpressure with stray starts. Signed 4 planes:
        // ch0 {3,-2,1,-1} -> 3-4+4+8 = 11; ch1 511 x4 -> -511; ch3 -512 x4 -> 512.
        clearStim();
        stim[0][0] = 3;  stim[1][0] = -2; stim[2][0] = 1;  stim[3][0] = -1;
        for (int i = 0; i < 4; i++) begin
            stim[i][1] = 511;
            stim[i][3] = -512;
        end
        applyStimulus(4, 1'b1, 0, 4);
        checkOutput("t4_ch0", chanOf(lastOut, 0), 11);
        checkOutput("t4_ch1", chanOf(lastOut, 1), -511);
        checkOutput("t4_ch3", chanOf(lastOut, 3), 512);
        finishTxn(5, 1'b1);

        // nbits = 0 clamps to 8 planes, unsigned: ch3 = 2 x 255 = 510.
        clearStim();
        for (int i = 0; i < 8; i++) stim[i][3] = 2;
        applyStimulus(0, 1'b0, 0, 8);
        checkOutput("t5_ch3", chanOf(lastOut, 3), 510);
        finishTxn(0, 1'b0);

        // Abort after 3 beats, with a beat offered in the abort cycle.
        clearStim();
        for (int i = 0; i < 8; i++) stim[i][0] = 7;
        applyStimulus(8, 1'b1, 0, 3);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_in_ready", bus.in_ready, 0);
        checkOutput("abort_acc_cleared", (bus.out_data === '0) ? 1 : 0, 1);

        clearStim();
        stim[0][0] = 1;
        stim[1][0] = 1;
        applyStimulus(2, 1'b0, 0, 2);
        checkOutput("after_abort_ch0", chanOf(lastOut, 0), 3);
        finishTxn(0, 1'b0);

        // Reset after 3 beats.
        clearStim();
        for (int i = 0; i < 8; i++) stim[i][1] = -5;
        applyStimulus(8, 1'b0, 0, 3);
        RSTN = 1'b0;
        #1;
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_out_valid", bus.out_valid, 0);
        checkOutput("rst_mid_acc_cleared", (bus.out_data === '0) ? 1 : 0, 1);
        @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);

        clearStim();
        stim[0][0] = 1;
        stim[1][0] = 1;
        applyStimulus(2, 1'b0, 0, 2);
        checkOutput("after_reset_ch0", chanOf(lastOut, 0), 3);
        checkOutput("after_reset_ch1", chanOf(lastOut, 1), 0);
        finishTxn(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
